// File: rtl/jtframe_pocket_vmeasure.sv
// jtframe_pocket_vmeasure
// Measures the Pocket video output timing as seen by the APF bridge and
// publishes one set of results per frame.
//
// Ports:
//   clk, rst_n                 system clock / async active-low reset
//   pck_rgb_clk                pixel clock level, toggled in the clk domain
//   pck_de, pck_hs, pck_vs     video timing, sampled on pixel-clock rising edges
//   hactive, htotal            widest active line / last line length (pixels)
//   vactive, vtotal            lines carrying DE / total lines (last frame)
//   frame_cnt                  number of published frames (wraps)
//   new_frame, mode_change     one-clk pulses on publish / on changed publish
//   stable                     STABLE_FRAMES identical frames in a row
module jtframe_pocket_vmeasure #(
    parameter int HW            = 12,
    parameter int VW            = 10,
    parameter int STABLE_FRAMES = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pck_rgb_clk,
    input  logic          pck_de,
    input  logic          pck_hs,
    input  logic          pck_vs,
    output logic [HW-1:0] hactive,
    output logic [HW-1:0] htotal,
    output logic [VW-1:0] vactive,
    output logic [VW-1:0] vtotal,
    output logic [7:0]    frame_cnt,
    output logic          new_frame,
    output logic          mode_change,
    output logic          stable
);

    typedef enum logic { WAIT_VS, MEASURE } state_t;

    state_t        st, st_nx;
    logic          rgb_clk_d;
    logic          px_tick;
    logic [HW-1:0] hcnt, hcnt_nx, dcnt, dcnt_nx, hmax, hmax_nx, last_ht, last_ht_nx;
    logic [VW-1:0] vact, vact_nx, vcnt, vcnt_nx;
    logic [3:0]    stab_cnt, stab_cnt_nx, stab_inc;
    logic          first_pub, first_pub_nx;
    logic [HW-1:0] hactive_nx, htotal_nx;
    logic [VW-1:0] vactive_nx, vtotal_nx;
    logic [7:0]    frame_cnt_nx;
    logic          new_frame_nx, mode_change_nx, stable_nx;
    logic          same;

    assign px_tick = pck_rgb_clk & ~rgb_clk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= WAIT_VS;
            rgb_clk_d   <= 1'b0;
            hcnt        <= '0;
            dcnt        <= '0;
            hmax        <= '0;
            last_ht     <= '0;
            vact        <= '0;
            vcnt        <= '0;
            stab_cnt    <= '0;
            first_pub   <= 1'b1;
            hactive     <= '0;
            htotal      <= '0;
            vactive     <= '0;
            vtotal      <= '0;
            frame_cnt   <= '0;
            new_frame   <= 1'b0;
            mode_change <= 1'b0;
            stable      <= 1'b0;
        end else begin
            st          <= st_nx;
            rgb_clk_d   <= pck_rgb_clk;
            hcnt        <= hcnt_nx;
            dcnt        <= dcnt_nx;
            hmax        <= hmax_nx;
            last_ht     <= last_ht_nx;
            vact        <= vact_nx;
            vcnt        <= vcnt_nx;
            stab_cnt    <= stab_cnt_nx;
            first_pub   <= first_pub_nx;
            hactive     <= hactive_nx;
            htotal      <= htotal_nx;
            vactive     <= vactive_nx;
            vtotal      <= vtotal_nx;
            frame_cnt   <= frame_cnt_nx;
            new_frame   <= new_frame_nx;
            mode_change <= mode_change_nx;
            stable      <= stable_nx;
        end
    end

    always_comb begin
        st_nx          = st;
        hcnt_nx        = hcnt;
        dcnt_nx        = dcnt;
        hmax_nx        = hmax;
        last_ht_nx     = last_ht;
        vact_nx        = vact;
        vcnt_nx        = vcnt;
        stab_cnt_nx    = stab_cnt;
        first_pub_nx   = first_pub;
        hactive_nx     = hactive;
        htotal_nx      = htotal;
        vactive_nx     = vactive;
        vtotal_nx      = vtotal;
        frame_cnt_nx   = frame_cnt;
        new_frame_nx   = 1'b0;
        mode_change_nx = 1'b0;
        stable_nx      = stable;
        same           = 1'b0;
        stab_inc       = (stab_cnt == 4'(STABLE_FRAMES)) ? stab_cnt : stab_cnt + 4'd1;

        if (px_tick) begin
            case (st)
                WAIT_VS: begin
                    if (pck_vs) begin
                        st_nx        = MEASURE;
                        hcnt_nx      = '0;
                        dcnt_nx      = '0;
                        hmax_nx      = '0;
                        last_ht_nx   = '0;
                        vact_nx      = '0;
                        vcnt_nx      = '0;
                        first_pub_nx = 1'b1;
                    end
                end
                MEASURE: begin
                    hcnt_nx = (hcnt == '1) ? hcnt : hcnt + 1'b1;
                    if (pck_de)
                        dcnt_nx = (dcnt == '1) ? dcnt : dcnt + 1'b1;
                    // Line close uses the pre-tick counts; the hs pixel
                    // itself opens the next line.
                    if (pck_hs) begin
                        last_ht_nx = hcnt;
                        if (dcnt > hmax)
                            hmax_nx = dcnt;
                        if (dcnt != '0)
                            vact_nx = (vact == '1) ? vact : vact + 1'b1;
                        vcnt_nx = (vcnt == '1) ? vcnt : vcnt + 1'b1;
                        hcnt_nx = HW'(1);
                        dcnt_nx = HW'(pck_de);
                    end
                    // Frame close sees the values that include this tick's
                    // line close, so hs+vs on one tick counts that line here.
                    if (pck_vs) begin
                        same = !first_pub &&
                               hmax_nx == hactive && last_ht_nx == htotal &&
                               vact_nx == vactive && vcnt_nx == vtotal;
                        hactive_nx   = hmax_nx;
                        htotal_nx    = last_ht_nx;
                        vactive_nx   = vact_nx;
                        vtotal_nx    = vcnt_nx;
                        frame_cnt_nx = frame_cnt + 8'd1;
                        new_frame_nx = 1'b1;
                        first_pub_nx = 1'b0;
                        if (same) begin
                            stab_cnt_nx = stab_inc;
                            stable_nx   = (stab_inc == 4'(STABLE_FRAMES));
                        end else begin
                            stab_cnt_nx    = '0;
                            stable_nx      = 1'b0;
                            mode_change_nx = 1'b1;
                        end
                        hmax_nx = '0;
                        vact_nx = '0;
                        vcnt_nx = '0;
                    end else if (vcnt_nx == '1) begin
                        // Lost vsync: drop the partial frame, keep published values
                        st_nx       = WAIT_VS;
                        stable_nx   = 1'b0;
                        stab_cnt_nx = '0;
                        hcnt_nx     = '0;
                        dcnt_nx     = '0;
                        hmax_nx     = '0;
                        last_ht_nx  = '0;
                        vact_nx     = '0;
                        vcnt_nx     = '0;
                    end
                end
                default: st_nx = WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_pocket_vmeasure.sv
// Directed bench for jtframe_pocket_vmeasure with a publish scoreboard.
// Uses HW=8 / VW=6 so that a lost-vsync saturation (63 lines) is reachable
// quickly. Frames are 14 lines; DE covers lines 2..9, pixels 2..2+dw-1.
module tb_jtframe_pocket_vmeasure;

    localparam int HW = 8;
    localparam int VW = 6;

    typedef struct {
        logic [HW-1:0] ha;
        logic [HW-1:0] ht;
        logic [VW-1:0] va;
        logic [VW-1:0] vt;
        logic [7:0]    fc;
        logic          mc;
        logic          st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pck_rgb_clk = 1'b0;
    logic          pck_de = 1'b0;
    logic          pck_hs = 1'b0;
    logic          pck_vs = 1'b0;
    logic [HW-1:0] hactive, htotal;
    logic [VW-1:0] vactive, vtotal;
    logic [7:0]    frame_cnt;
    logic          new_frame, mode_change, stable;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    jtframe_pocket_vmeasure #(.HW(HW), .VW(VW), .STABLE_FRAMES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pck_rgb_clk (pck_rgb_clk),
        .pck_de      (pck_de),
        .pck_hs      (pck_hs),
        .pck_vs      (pck_vs),
        .hactive     (hactive),
        .htotal      (htotal),
        .vactive     (vactive),
        .vtotal      (vtotal),
        .frame_cnt   (frame_cnt),
        .new_frame   (new_frame),
        .mode_change (mode_change),
        .stable      (stable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int ha, input int ht, input int va, input int vt,
                        input int fc, input bit mc, input bit st);
        exp_t e;
        e.ha = HW'(ha); e.ht = HW'(ht); e.va = VW'(va); e.vt = VW'(vt);
        e.fc = 8'(fc);  e.mc = mc;      e.st = st;
        expq.push_back(e);
    endtask

    // Monitor: every new_frame pulse must match the next queued publish.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mode_change && !new_frame) begin
                checks++; errors++;
                $display("FAIL mode_change_alone: got 1 expected 0");
            end
            if (new_frame) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_publish: got frame_cnt %0d expected no publish", frame_cnt);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("hactive",     32'(hactive),     32'(e.ha));
                    check("htotal",      32'(htotal),      32'(e.ht));
                    check("vactive",     32'(vactive),     32'(e.va));
                    check("vtotal",      32'(vtotal),      32'(e.vt));
                    check("frame_cnt",   32'(frame_cnt),   32'(e.fc));
                    check("mode_change", 32'(mode_change), 32'(e.mc));
                    check("stable",      32'(stable),      32'(e.st));
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_hactive"},   32'(hactive),     32'd0);
        check({tag, "_htotal"},    32'(htotal),      32'd0);
        check({tag, "_vactive"},   32'(vactive),     32'd0);
        check({tag, "_vtotal"},    32'(vtotal),      32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt),   32'd0);
        check({tag, "_new_frame"}, 32'(new_frame),   32'd0);
        check({tag, "_mode_chg"},  32'(mode_change), 32'd0);
        check({tag, "_stable"},    32'(stable),      32'd0);
    endtask

    task automatic pixel(input bit de, input bit hs, input bit vs);
        @(negedge clk);
        pck_rgb_clk = 1'b1;
        pck_de = de; pck_hs = hs; pck_vs = vs;
        @(negedge clk);
        pck_rgb_clk = 1'b0;
        pck_de = 1'b0; pck_hs = 1'b0; pck_vs = 1'b0;
    endtask

    task automatic frame(input int ht, input int dw, input bit vs_late,
                         input bit do_stall, input bit do_rst);
        for (int l = 0; l < 14; l++) begin
            for (int p = 0; p < ht; p++) begin
                if (do_stall && l == 5 && p == 10)
                    repeat (1000) @(negedge clk);
                if (do_rst && l == 3 && p == 5) begin
                    #3 rst_n = 1'b0;
                    #1 check_zero("midrst");
                    repeat (3) @(posedge clk);
                    #2 rst_n = 1'b1;
                end
                pixel(l >= 2 && l <= 9 && p >= 2 && p < 2 + dw,
                      p == 0,
                      l == 0 && p == (vs_late ? 1 : 0));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        #3 rst_n = 1'b1;

        frame(24, 16, 0, 0, 0);                    // first vs: no publish
        push(16, 24, 8, 14, 1, 1, 0); frame(24, 16, 0, 0, 0);
        push(16, 24, 8, 14, 2, 0, 0); frame(24, 16, 0, 0, 0);
        push(16, 24, 8, 14, 3, 0, 0); frame(24, 16, 0, 0, 0);
        push(16, 24, 8, 14, 4, 0, 0); frame(24, 16, 0, 0, 0);
        push(16, 24, 8, 14, 5, 0, 1); frame(24, 16, 0, 0, 0);
        push(16, 24, 8, 14, 6, 0, 1); frame(24, 16, 0, 0, 0);
        // mode switch
        push(16, 24, 8, 14, 7, 0, 1); frame(28, 20, 0, 0, 0);
        push(20, 28, 8, 14, 8, 1, 0); frame(28, 20, 0, 0, 0);
        push(20, 28, 8, 14, 9, 0, 0); frame(28, 20, 0, 0, 0);
        push(20, 28, 8, 14, 10, 0, 0); frame(28, 20, 0, 0, 0);
        push(20, 28, 8, 14, 11, 0, 0); frame(28, 20, 0, 0, 0);
        push(20, 28, 8, 14, 12, 0, 1); frame(28, 20, 0, 0, 0);
        // vs one pixel after hs: line count unchanged
        push(20, 28, 8, 14, 13, 0, 1); frame(28, 20, 1, 0, 0);
        push(20, 28, 8, 14, 14, 0, 1); frame(28, 20, 1, 0, 0);
        push(20, 28, 8, 14, 15, 0, 1); frame(28, 20, 0, 0, 0);
        // lost vsync: 13 + 60 hs ticks saturates the 6-bit line counter
        for (int l = 0; l < 60; l++)
            for (int p = 0; p < 28; p++)
                pixel(1'b0, p == 0, 1'b0);
        check("sat_stable",    32'(stable),    32'd0);
        check("sat_hactive",   32'(hactive),   32'd20);
        check("sat_htotal",    32'(htotal),    32'd28);
        check("sat_vactive",   32'(vactive),   32'd8);
        check("sat_vtotal",    32'(vtotal),    32'd14);
        check("sat_frame_cnt", 32'(frame_cnt), 32'd15);
        frame(28, 20, 0, 0, 0);                    // re-sync vs: no publish
        push(20, 28, 8, 14, 16, 1, 0); frame(28, 20, 0, 0, 0);
        // pixel clock stall mid-frame
        push(20, 28, 8, 14, 17, 0, 0); frame(28, 20, 0, 1, 0);
        push(20, 28, 8, 14, 18, 0, 0); frame(28, 20, 0, 0, 0);
        // reset mid-line after this frame's publish
        push(20, 28, 8, 14, 19, 0, 0); frame(28, 20, 0, 0, 1);
        check("postrst_frame_cnt", 32'(frame_cnt), 32'd0);
        frame(28, 20, 0, 0, 0);                    // first vs after reset: no publish
        push(20, 28, 8, 14, 1, 1, 0); frame(28, 20, 0, 0, 0);

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_pocket_vmeasure.md
Name: jtframe_pocket_vmeasure

Overview:
- Downstream monitor of the Pocket video output stage. It consumes the same pck_rgb_clk / pck_de / pck_hs / pck_vs the APF bridge receives.
- Measures per-frame active width, active height, line total and frame total in output-pixel units.
- Reports the values to the Pocket bridge/status registers together with a stability flag, a frame counter and change pulses.
- Runs entirely in the clk domain that generates pck_rgb_clk.

Parameters:
- HW, 12, width of horizontal counters/outputs (pixels).
- VW, 10, width of vertical counters/outputs (lines).
- STABLE_FRAMES, 4, consecutive identical frames required before stable rises (1..15).

Ports:
- clk  in  1  system clock, same clock that produces pck_rgb_clk.
- rst_n  in  1  asynchronous active-low reset.
- pck_rgb_clk  in  1  Pocket pixel clock, a level toggled in clk domain.
- pck_de  in  1  data enable.
- pck_hs  in  1  one-pixel hsync pulse.
- pck_vs  in  1  one-pixel vsync pulse.
- hactive  out  HW  max active pixels per line in last frame.
- htotal  out  HW  pixel ticks per line, last complete line of last frame.
- vactive  out  VW  lines with at least one DE pixel in last frame.
- vtotal  out  VW  hs ticks in last frame.
- frame_cnt  out  8  completed measured frames, wraps.
- new_frame  out  1  1-clk pulse when outputs update.
- mode_change  out  1  1-clk pulse when an update differs from the previous frame.
- stable  out  1  STABLE_FRAMES consecutive identical frames seen.

Behaviour:
- Tick generation:
  - px_tick = pck_rgb_clk & ~pck_rgb_clk_d (rising edge, d = 1-clk delayed copy).
  - pck_de/hs/vs are sampled only on the clk where px_tick=1. All counters advance only on px_tick.
- Reset (rst_n=0, asynchronous):
  - All outputs 0. State = WAIT_VS. All counters and stab_cnt 0. pck_rgb_clk_d=0.
- States:
  - WAIT_VS: counters held at 0. A vs tick moves to MEASURE, clears all counters and publishes nothing. The first partial frame is never reported.
  - MEASURE: accumulates as below. A vs tick publishes; the state stays MEASURE.
- Per px_tick in MEASURE:
  - hcnt += 1 (saturating at all-ones).
  - If de: dcnt += 1 (saturating).
  - On an hs tick, the line closes first:
    - last_ht <= hcnt.
    - If dcnt > hmax: hmax <= dcnt.
    - If dcnt != 0: vact += 1.
    - vcnt += 1.
    - Then hcnt <= 1 and dcnt <= de. The hs tick's own pixel belongs to the new line.
  - Vertical counters saturate at all-ones.
  - Saturation of vcnt (no vs for 2^VW-1 lines): go to WAIT_VS, clear stable and stab_cnt, no publish.
- hs and vs on the same tick:
  - Line close happens first. The frame then closes, including that line.
- Frame close (vs tick in MEASURE):
  - Takes effect on the same clk edge. Outputs visible 1 clk after the px_tick clk.
  - hactive <= hmax, htotal <= last_ht, vactive <= vact, vtotal <= vcnt (values including that edge's line close).
  - frame_cnt += 1 (8-bit wrap). new_frame = 1 for exactly one clk.
  - Clear hmax, vact, vcnt. Do not clear hcnt/dcnt, since the line continues.
- Stability check, comparing the 4-tuple against the currently published values before the update:
  - Equal: stab_cnt += 1, saturating at STABLE_FRAMES. stable = (stab_cnt == STABLE_FRAMES), registered.
  - Different: stab_cnt <= 0, stable <= 0, mode_change = 1 for one clk.
  - The very first publish after WAIT_VS always counts as different: mode_change pulses.
- Latency: outputs and pulses appear 1 clk after the vs px_tick clk. pck_rgb_clk stalled means no ticks, so all values hold.
- Reset mid-frame: immediate return to reset values. The next measurement starts only after a subsequent vs.

Test Plan:
- 384 px/line, DE on 256 px for lines 16..239, vs every 262 lines, 6 frames → first publish after the 2nd vs: hactive=256, htotal=384, vactive=224, vtotal=262; mode_change pulses once, frame_cnt=1; stable rises with the 5th publish (4 equal frames after the first); new_frame pulses once per frame, one clk each.
- Same timing, switch to DE 320 px / htotal 424 at frame 4 → that publish gives hactive=320, htotal=424; mode_change pulses; stable drops the same clk and reasserts 4 frames later.
- hs and vs asserted on the same tick versus vs one pixel after hs → the two cases report vtotal differing by exactly 0, with the line counted in the closing frame in both cases.
- Stop vs for 1023+ lines with hs running → state returns to WAIT_VS; stable=0; outputs hold their last values; the next vs publishes nothing; the following vs publishes and mode_change pulses.
- Assert rst_n low mid-line for 3 clks, asynchronously to clk → all outputs 0 immediately; no publish on the first vs after release.
- pck_rgb_clk held static for 1000 clks mid-frame → counters frozen; resuming yields the same htotal/vtotal as without the stall.
